// File: rtl/ltl_symbol_feeder.sv
// Feeds buffered proposition vectors to an LTL monitor as one symbol per cycle.
// It also sequences the monitor reset so that reset drops on the same cycle as the first symbol of each trace.
module ltl_symbol_feeder #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int RESET_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trace_start,
  input  logic                    prop_valid,
  output logic                    prop_ready,
  input  logic [SYMBOL_WIDTH-1:0] prop_bits,
  output logic [SYMBOL_WIDTH-1:0] symbols,
  output logic                    run,
  output logic                    monitor_reset,
  output logic                    busy,
  output logic [31:0]             symbol_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] ARM_LOAD   = AW'(RESET_CYCLES);

  typedef enum logic {
    ST_ARM,
    ST_STREAM
  } state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           arm_cnt_q, arm_cnt_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [SYMBOL_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [SYMBOL_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [SYMBOL_WIDTH-1:0] symbols_q, symbols_d;
  logic                    run_q, run_d;
  logic                    mreset_q, mreset_d;
  logic [31:0]             sym_cnt_q, sym_cnt_d;
  logic                    push;
  logic                    pop;
  logic                    non_empty;
  logic [SYMBOL_WIDTH-1:0] head;

  // No pass-through: a full buffer refuses data even if it pops this cycle.
  assign prop_ready = !reset && (count_q != FULL_COUNT);
  assign push       = prop_valid && prop_ready;
  assign non_empty  = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = prop_bits;
    end
  end

  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    symbols_d = symbols_q;
    run_d     = run_q;
    mreset_d  = mreset_q;
    sym_cnt_d = sym_cnt_q;
    pop       = 1'b0;

    if (trace_start) begin
      // Drop the old contents; a beat arriving now becomes the only entry.
      rd_ptr_d  = wr_ptr_q;
      wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      count_d   = push ? CW'(1) : '0;
      run_d     = 1'b0;
      mreset_d  = 1'b1;
      sym_cnt_d = '0;
      arm_cnt_d = ARM_LOAD;
      state_d   = ST_ARM;
    end else begin
      unique case (state_q)
        ST_ARM: begin
          run_d    = 1'b0;
          mreset_d = 1'b1;
          // Release happens on the edge where the count reaches zero,
          // so the reset is held for exactly RESET_CYCLES cycles.
          if (arm_cnt_q > AW'(1)) begin
            arm_cnt_d = arm_cnt_q - AW'(1);
          end else begin
            arm_cnt_d = '0;
            if (non_empty) begin
              pop       = 1'b1;
              symbols_d = head;
              run_d     = 1'b1;
              mreset_d  = 1'b0;
              sym_cnt_d = 32'd1;
              state_d   = ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          mreset_d = 1'b0;
          if (non_empty) begin
            pop       = 1'b1;
            symbols_d = head;
            run_d     = 1'b1;
            sym_cnt_d = (sym_cnt_q == '1) ? sym_cnt_q : sym_cnt_q + 32'd1;
          end else begin
            run_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_ARM;
        end
      endcase

      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ARM;
      arm_cnt_q <= ARM_LOAD;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      symbols_q <= '0;
      run_q     <= 1'b0;
      mreset_q  <= 1'b1;
      sym_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      symbols_q <= symbols_d;
      run_q     <= run_d;
      mreset_q  <= mreset_d;
      sym_cnt_q <= sym_cnt_d;
    end
  end

  assign symbols       = symbols_q;
  assign run           = run_q;
  assign monitor_reset = mreset_q;
  assign symbol_count  = sym_cnt_q;
  assign busy          = (state_q == ST_ARM) || non_empty || run_q;

endmodule

// File: tb/tb_ltl_symbol_feeder.sv
// Self-checking bench for ltl_symbol_feeder: directed trace scenarios followed by random traffic.
// Every cycle is compared against a queue-based reference model.
module tb_ltl_symbol_feeder;

  localparam int SW    = 8;
  localparam int DEPTH = 8;
  // A long arming window lets the buffer fill before the first symbol is issued.
  localparam int RC    = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          trace_start = 1'b0;
  logic          prop_valid = 1'b0;
  logic          prop_ready;
  logic [SW-1:0] prop_bits = '0;
  logic [SW-1:0] symbols;
  logic          run;
  logic          monitor_reset;
  logic          busy;
  logic [31:0]   symbol_count;

  int total = 0;
  int bad   = 0;

  logic [SW-1:0] m_q[$];
  bit            m_arming  = 1'b1;
  int            m_elapsed = 0;
  logic [SW-1:0] m_sym     = '0;
  bit            m_run     = 1'b0;
  bit            m_mr      = 1'b1;
  logic [31:0]   m_cnt     = '0;
  bit            m_init    = 1'b0;
  bit            m_acc     = 1'b0;

  always #5 clk = ~clk;

  ltl_symbol_feeder #(
    .SYMBOL_WIDTH(SW),
    .FIFO_DEPTH  (DEPTH),
    .RESET_CYCLES(RC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .trace_start  (trace_start),
    .prop_valid   (prop_valid),
    .prop_ready   (prop_ready),
    .prop_bits    (prop_bits),
    .symbols      (symbols),
    .run          (run),
    .monitor_reset(monitor_reset),
    .busy         (busy),
    .symbol_count (symbol_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance the model, check registered outputs.
  task automatic applyStimulus(input bit rst, input bit ts, input bit v, input logic [SW-1:0] d);
    bit exp_ready;
    @(negedge clk);
    reset       = rst;
    trace_start = ts;
    prop_valid  = v;
    prop_bits   = d;
    #1;
    exp_ready = !rst && (m_q.size() != DEPTH);
    checkOutput("prop_ready", 32'(prop_ready), 32'(exp_ready));
    if (m_init) begin
      checkOutput("busy", 32'(busy), 32'(m_arming || (m_q.size() != 0) || m_run));
    end
    m_acc = v && exp_ready;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_arming  = 1'b1;
      m_elapsed = 0;
      m_sym     = '0;
      m_run     = 1'b0;
      m_mr      = 1'b1;
      m_cnt     = '0;
      m_init    = 1'b1;
    end else if (ts) begin
      m_q.delete();
      if (m_acc) m_q.push_back(d);
      m_arming  = 1'b1;
      m_elapsed = 0;
      m_run     = 1'b0;
      m_mr      = 1'b1;
      m_cnt     = '0;
    end else begin
      if (m_arming) begin
        if ((m_elapsed + 1 >= RC) && (m_q.size() != 0)) begin
          m_sym    = m_q.pop_front();
          m_run    = 1'b1;
          m_mr     = 1'b0;
          m_cnt    = 32'd1;
          m_arming = 1'b0;
        end else begin
          if (m_elapsed < RC) m_elapsed++;
          m_run = 1'b0;
        end
      end else if (m_q.size() != 0) begin
        m_sym = m_q.pop_front();
        m_run = 1'b1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end else begin
        m_run = 1'b0;
      end
      if (m_acc) m_q.push_back(d);
    end
    #1;
    if (m_init) begin
      checkOutput("symbols", 32'(symbols), 32'(m_sym));
      checkOutput("run", 32'(run), 32'(m_run));
      checkOutput("monitor_reset", 32'(monitor_reset), 32'(m_mr));
      checkOutput("symbol_count", symbol_count, m_cnt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Holds a beat on the bus until the model says it was taken, with a cycle bound.
  task automatic pushBeat(input logic [SW-1:0] d, input bit ts);
    int tries;
    tries = 0;
    m_acc = 1'b0;
    while (!m_acc && tries < 40) begin
      applyStimulus(1'b0, ts && (tries == 0), 1'b1, d);
      tries++;
    end
    checkOutput("push_accepted", 32'(m_acc), 32'd1);
  endtask

  initial begin
    int mode;
    $display("[TB] start");

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    pushBeat(8'h12, 1'b0);
    idle(RC + 3);

    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    idle(RC + 6);
    pushBeat(8'h3C, 1'b0);
    idle(3);

    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 1; i <= 9; i++) pushBeat(SW'(i), 1'b0);
    idle(RC + 4);

    pushBeat(8'h55, 1'b0);
    idle(4);
    pushBeat(8'h66, 1'b0);
    idle(3);

    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    pushBeat(8'h11, 1'b0);
    pushBeat(8'h22, 1'b0);
    pushBeat(8'h33, 1'b0);
    pushBeat(8'hA5, 1'b1);
    idle(RC + 3);

    pushBeat(8'h77, 1'b1);
    idle(RC + 3);

    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) pushBeat(SW'(8'hC0 + i), 1'b0);
    idle(RC - 5);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    idle(RC + 4);

    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      bit r, t, v;
      if (c % 40 == 0) mode = int'($urandom_range(0, 2));
      r = ($urandom_range(0, 199) == 0);
      t = ($urandom_range(0, 59) == 0);
      case (mode)
        0:       v = ($urandom_range(0, 9) == 0);
        1:       v = ($urandom_range(0, 1) == 0);
        default: v = ($urandom_range(0, 19) != 0);
      endcase
      applyStimulus(r, t, v, SW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
